// File: rtl/dmem_pkg.sv
// dmem_pkg: shared owner encoding and default sizes for the data-memory arbiter
// Contents:
//   owner_t      which requester drives the memory this cycle (none/core/DMA)
//   DEF_AW       default word-address width
//   DEF_DW       default data width
//   DEF_DEPTH    default number of memory words; higher addresses are out of range
//   DEF_STARVE   default number of denied DMA cycles before a forced DMA beat
package dmem_pkg;
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    localparam int DEF_AW     = 32;
    localparam int DEF_DW     = 32;
    localparam int DEF_DEPTH  = 1024;
    localparam int DEF_STARVE = 4;
endpackage

// File: rtl/dmem_starve_ctr.sv
// dmem_starve_ctr: counts consecutive denied DMA cycles and raises a one-beat force flag
// Ports:
//   clk       in   clock
//   rst       in   asynchronous reset, active-low
//   dmaReq    in   DMA is requesting this cycle
//   dmaGnt    in   DMA was granted this cycle
//   forceDma  out  give the DMA priority over the core this cycle
module dmem_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dmaReq,
    input  logic dmaGnt,
    output logic forceDma
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starveCnt;
    logic [CW-1:0] cntNext;
    logic          forceNext;

    // The flag rises on the same edge the count reaches the limit, so the forced
    // beat lands in the very next cycle; it drops once that beat has been granted.
    always_comb begin
        cntNext   = (dmaReq & ~dmaGnt)
                  ? ((starveCnt == CW'(STARVE_MAX)) ? starveCnt : starveCnt + 1'b1)
                  : '0;
        forceNext = dmaGnt ? 1'b0 : (forceDma | (cntNext == CW'(STARVE_MAX)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starveCnt <= '0;
            forceDma  <= 1'b0;
        end else begin
            starveCnt <= cntNext;
            forceDma  <= forceNext;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core memory stage and a DMA/debug loader
// Ports:
//   clk, rst                          clock; asynchronous active-low reset
//   core_req/we/addr/wdata            core access request, held until granted
//   core_gnt                          core access accepted this cycle
//   core_rvalid/core_rdata            core load return, one cycle after acceptance
//   dma_req/we/addr/wdata             DMA access request, held until granted
//   dma_gnt                           DMA access accepted this cycle
//   dma_rvalid/dma_rdata              DMA read return, one cycle after acceptance
//   mem_we/mem_addr/mem_wdata         drive to the data memory
//   mem_rdata                         combinational read data from the data memory
//   stall_m                           core is requesting but not granted
//   addr_err                          one-cycle pulse after an accepted out-of-range access
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int STARVE_MAX = DEF_STARVE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_m,
    output logic          addr_err
);
    owner_t        owner;
    logic          forceDma;
    logic          selWe;
    logic          accErr;
    logic [DW-1:0] rdataIn;

    dmem_starve_ctr #(.STARVE_MAX(STARVE_MAX)) uStarve (
        .clk      (clk),
        .rst      (rst),
        .dmaReq   (dma_req),
        .dmaGnt   (dma_gnt),
        .forceDma (forceDma)
    );

    // Grants are held off while reset is asserted so the memory sees an idle bus.
    always_comb begin
        core_gnt  = rst & (forceDma ? core_req & ~dma_req : core_req);
        dma_gnt   = rst & (forceDma ? dma_req : dma_req & ~core_req);
        stall_m   = core_req & ~core_gnt;
        owner     = core_gnt ? OWN_CORE : dma_gnt ? OWN_DMA : OWN_NONE;
        selWe     = (owner == OWN_CORE) ? core_we : (owner == OWN_DMA) ? dma_we : 1'b0;
        mem_addr  = (owner == OWN_CORE) ? core_addr : (owner == OWN_DMA) ? dma_addr : '0;
        mem_wdata = (owner == OWN_CORE) ? core_wdata : (owner == OWN_DMA) ? dma_wdata : '0;
        accErr    = (owner != OWN_NONE) & ({1'b0, mem_addr} >= (AW + 1)'(DEPTH));
        mem_we    = selWe & ~accErr;
        rdataIn   = accErr ? '0 : mem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_rvalid <= 1'b0;
            core_rdata  <= '0;
            dma_rvalid  <= 1'b0;
            dma_rdata   <= '0;
            addr_err    <= 1'b0;
        end else begin
            core_rvalid <= core_gnt & ~core_we;
            dma_rvalid  <= dma_gnt & ~dma_we;
            addr_err    <= accErr;
            if (core_gnt & ~core_we)
                core_rdata <= rdataIn;
            if (dma_gnt & ~dma_we)
                dma_rdata <= rdataIn;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a small word memory model
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic        core_gnt, core_rvalid;
    logic [31:0] core_rdata;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_m, addr_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] tbMem [0:1023];

    always #5 clk = ~clk;

    // Out-of-range reads return a non-zero pattern so the arbiter's zeroing is visible.
    assign mem_rdata = (mem_addr < 32'd1024) ? tbMem[mem_addr[9:0]] : 32'hDEADBEEF;
    always @(posedge clk) if (mem_we && mem_addr < 32'd1024) tbMem[mem_addr[9:0]] <= mem_wdata;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_m(stall_m), .addr_err(addr_err)
    );

    task automatic idle();
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (core_gnt !== 1'b0 || dma_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt core=%b dma=%b want 0/0", core_gnt, dma_gnt); end
        checks++; if (core_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid core=%b dma=%b want 0/0", core_rvalid, dma_rvalid); end
        checks++; if (core_rdata !== 0 || dma_rdata !== 0) begin failures++; $display("FAIL reset_rdata core=%h dma=%h want 0/0", core_rdata, dma_rdata); end
        checks++; if (mem_we !== 1'b0 || mem_addr !== 0 || mem_wdata !== 0 || addr_err !== 1'b0) begin failures++; $display("FAIL reset_mem we=%b addr=%h wdata=%h err=%b want zeros", mem_we, mem_addr, mem_wdata, addr_err); end
        rst = 1;
    endtask

    task automatic test_core_load();
        @(negedge clk);
        core_req = 1; core_we = 0; core_addr = 28;
        #1;
        checks++; if (core_gnt !== 1'b1 || mem_addr !== 32'd28 || mem_we !== 1'b0) begin failures++; $display("FAIL core_load_gnt gnt=%b addr=%0d we=%b want 1/28/0", core_gnt, mem_addr, mem_we); end
        @(posedge clk); #1;
        checks++; if (core_rvalid !== 1'b1 || core_rdata !== 32'h000000F0) begin failures++; $display("FAIL core_load_data rvalid=%b rdata=%h want 1/000000f0", core_rvalid, core_rdata); end
        @(negedge clk); idle();
        @(posedge clk); #1;
        checks++; if (core_rvalid !== 1'b0 || core_rdata !== 32'h000000F0) begin failures++; $display("FAIL core_load_hold rvalid=%b rdata=%h want 0/000000f0", core_rvalid, core_rdata); end
    endtask

    task automatic test_dma_store_load();
        @(negedge clk);
        dma_req = 1; dma_we = 1; dma_addr = 41; dma_wdata = 32'h12345678;
        #1;
        checks++; if (dma_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd41 || mem_wdata !== 32'h12345678) begin failures++; $display("FAIL dma_store gnt=%b we=%b addr=%0d wdata=%h want 1/1/41/12345678", dma_gnt, mem_we, mem_addr, mem_wdata); end
        @(posedge clk); #1;
        checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL dma_store_norvalid rvalid=%b want 0", dma_rvalid); end
        @(negedge clk);
        dma_we = 0; dma_wdata = 0;
        @(posedge clk); #1;
        checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h12345678) begin failures++; $display("FAIL dma_load rvalid=%b rdata=%h want 1/12345678", dma_rvalid, dma_rdata); end
        @(negedge clk); idle();
    endtask

    task automatic test_starve();
        @(negedge clk);
        core_req = 1; core_addr = 5; dma_req = 1; dma_addr = 6;
        for (int c = 1; c <= 6; c++) begin
            #1;
            checks++; if (core_gnt !== (c != 5) || dma_gnt !== (c == 5) || stall_m !== (c == 5)) begin failures++; $display("FAIL starve_gnt cycle=%0d core=%b dma=%b stall=%b want %b/%b/%b", c, core_gnt, dma_gnt, stall_m, c != 5, c == 5, c == 5); end
            @(posedge clk); #1;
            checks++; if (core_rvalid !== (c != 5) || dma_rvalid !== (c == 5)) begin failures++; $display("FAIL starve_rvalid cycle=%0d core=%b dma=%b want %b/%b", c, core_rvalid, dma_rvalid, c != 5, c == 5); end
            @(negedge clk);
        end
        checks++; if (core_rdata !== 32'h55 || dma_rdata !== 32'h66) begin failures++; $display("FAIL starve_rdata core=%h dma=%h want 55/66", core_rdata, dma_rdata); end
        idle();
        @(posedge clk);
    endtask

    task automatic test_addr_err();
        @(negedge clk);
        core_req = 1; core_we = 1; core_addr = 1024; core_wdata = 32'hAAAA5555;
        #1;
        checks++; if (core_gnt !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL oob_store gnt=%b we=%b want 1/0", core_gnt, mem_we); end
        @(posedge clk); #1;
        checks++; if (addr_err !== 1'b1 || core_rvalid !== 1'b0) begin failures++; $display("FAIL oob_store_err err=%b rvalid=%b want 1/0", addr_err, core_rvalid); end
        @(negedge clk);
        core_we = 0; core_wdata = 0;
        @(posedge clk); #1;
        checks++; if (addr_err !== 1'b1 || core_rvalid !== 1'b1 || core_rdata !== 0) begin failures++; $display("FAIL oob_load err=%b rvalid=%b rdata=%h want 1/1/0", addr_err, core_rvalid, core_rdata); end
        @(negedge clk);
        core_addr = 1023;
        @(posedge clk); #1;
        checks++; if (addr_err !== 1'b0 || core_rdata !== 32'h3FF) begin failures++; $display("FAIL last_word err=%b rdata=%h want 0/3ff", addr_err, core_rdata); end
        @(negedge clk); idle();
        @(posedge clk); #1;
        checks++; if (addr_err !== 1'b0 || core_rvalid !== 1'b0) begin failures++; $display("FAIL err_pulse err=%b rvalid=%b want 0/0", addr_err, core_rvalid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        core_req = 1; core_addr = 5; dma_req = 1; dma_addr = 41;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL mid_forced dma_gnt=%b want 1", dma_gnt); end
        rst = 0;
        #1;
        checks++; if (core_gnt !== 1'b0 || dma_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 0 || mem_wdata !== 0) begin failures++; $display("FAIL mid_idle core=%b dma=%b we=%b addr=%h wdata=%h want zeros", core_gnt, dma_gnt, mem_we, mem_addr, mem_wdata); end
        @(posedge clk); #1;
        checks++; if (dma_rvalid !== 1'b0 || dma_rdata !== 0 || addr_err !== 1'b0) begin failures++; $display("FAIL mid_return rvalid=%b rdata=%h err=%b want 0/0/0", dma_rvalid, dma_rdata, addr_err); end
        checks++; if (dut.uStarve.starveCnt !== 0 || dut.uStarve.forceDma !== 1'b0) begin failures++; $display("FAIL mid_ctr cnt=%0d force=%b want 0/0", dut.uStarve.starveCnt, dut.uStarve.forceDma); end
        @(negedge clk);
        rst = 1;
        #1;
        checks++; if (core_gnt !== 1'b1 || dma_gnt !== 1'b0) begin failures++; $display("FAIL mid_release core=%b dma=%b want 1/0", core_gnt, dma_gnt); end
        idle();
        @(posedge clk);
    endtask

    task automatic test_drop();
        @(negedge clk);
        core_req = 1; core_addr = 5; dma_req = 1; dma_addr = 6;
        repeat (3) @(negedge clk);
        dma_req = 0;
        @(negedge clk);
        checks++; if (dut.uStarve.starveCnt !== 0 || dut.uStarve.forceDma !== 1'b0) begin failures++; $display("FAIL drop_clear cnt=%0d force=%b want 0/0", dut.uStarve.starveCnt, dut.uStarve.forceDma); end
        dma_req = 1;
        for (int c = 1; c <= 5; c++) begin
            #1;
            checks++; if (dma_gnt !== (c == 5) || core_gnt !== (c != 5)) begin failures++; $display("FAIL drop_regrant cycle=%0d dma=%b core=%b want %b/%b", c, dma_gnt, core_gnt, c == 5, c != 5); end
            @(negedge clk);
        end
        idle();
        @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) tbMem[i] = 32'h0;
        tbMem[28]   = 32'h000000F0;
        tbMem[5]    = 32'h00000055;
        tbMem[6]    = 32'h00000066;
        tbMem[1023] = 32'h000003FF;
        test_reset();
        test_core_load();
        test_dma_store_load();
        test_starve();
        test_addr_err();
        test_reset_mid();
        test_drop();
        checks++; if (tbMem[41] !== 32'h12345678) begin failures++; $display("FAIL mem_41 got=%h want 12345678", tbMem[41]); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
